// File: rtl/sram_frame_master_if.sv
// Stream and SRAM signal bundle for sram_frame_master.
// master: the frame master itself; slave: the surrounding producer, consumer and SRAM.
interface sram_frame_master_if #(
    parameter int A_WIDTH = 17,
    parameter int D_WIDTH = 8
);
    logic               Wr_Valid;
    logic               Wr_Ready;
    logic [D_WIDTH-1:0] Wr_Data;
    logic               Rd_Start;
    logic               Rd_Valid;
    logic               Rd_Ready;
    logic [D_WIDTH-1:0] Rd_Data;
    logic               Rd_Last;
    logic               Busy;
    logic               Frame_Done;
    logic               Sram_En;
    logic               Sram_RW;
    logic [A_WIDTH-1:0] Sram_Addr;
    logic [D_WIDTH-1:0] Sram_Din;
    logic [D_WIDTH-1:0] Sram_Dout;

    modport master (
        input  Wr_Valid, Wr_Data, Rd_Start, Rd_Ready, Sram_Dout,
        output Wr_Ready, Rd_Valid, Rd_Data, Rd_Last, Busy, Frame_Done,
               Sram_En, Sram_RW, Sram_Addr, Sram_Din
    );

    modport slave (
        output Wr_Valid, Wr_Data, Rd_Start, Rd_Ready, Sram_Dout,
        input  Wr_Ready, Rd_Valid, Rd_Data, Rd_Last, Busy, Frame_Done,
               Sram_En, Sram_RW, Sram_Addr, Sram_Din
    );
endinterface

// File: rtl/sram_frame_master.sv
// Frame master for the single-port pixel SRAM: stores one raster frame from the
// write stream at linear addresses, then on command streams it back in raster
// order. Reads run ahead of the consumer into a 4-entry buffer so the SRAM's
// one-cycle read latency and zero-when-idle data never reach the read stream.
module sram_frame_master #(
    parameter int A_WIDTH = 17,
    parameter int D_WIDTH = 8,
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240
) (
    input  logic                Clk,
    input  logic                Rst_n,
    sram_frame_master_if.master bus
);
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int DEPTH = 4;
    localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(NPIX - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2} state_t;

    state_t             state_reg;
    logic [A_WIDTH-1:0] wr_cnt_reg;
    logic [A_WIDTH-1:0] rd_cnt_reg;
    logic               rd_all_issued_reg;  // final address already requested
    logic               issue_last_reg;     // read launched last edge targets the final address
    logic               pend_reg;           // SRAM data for an earlier read is on Sram_Dout now
    logic               pend_last_reg;
    logic               sram_en_reg;
    logic               sram_rw_reg;
    logic [A_WIDTH-1:0] sram_addr_reg;
    logic [D_WIDTH-1:0] sram_din_reg;
    logic               frame_done_reg;
    logic [D_WIDTH-1:0] buf_data_reg [DEPTH];
    logic               buf_last_reg [DEPTH];
    logic [1:0]         head_reg;
    logic [1:0]         tail_reg;
    logic [2:0]         occ_reg;

    logic       wr_ready;
    logic       wr_fire;
    logic       rd_valid;
    logic       pop;
    logic       issue_now;
    logic       rd_issue;
    logic [3:0] level;

    // Handshakes and read credit: buffered + in-flight after this edge must stay within DEPTH
    always_comb begin
        wr_ready  = ((state_reg == IDLE) && !bus.Rd_Start) || (state_reg == WR);
        wr_fire   = wr_ready && bus.Wr_Valid;
        rd_valid  = (occ_reg != 3'd0);
        pop       = rd_valid && bus.Rd_Ready;
        issue_now = sram_en_reg && !sram_rw_reg;
        level     = 4'(occ_reg) + 4'(issue_now) + 4'(pend_reg) - 4'(pop);
        rd_issue  = (state_reg == RD) && !rd_all_issued_reg && (level < 4'(DEPTH));
    end

    // Control FSM: mode selection, write beats, read issue and the registered SRAM command
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg         <= IDLE;
            wr_cnt_reg        <= '0;
            rd_cnt_reg        <= '0;
            rd_all_issued_reg <= 1'b0;
            issue_last_reg    <= 1'b0;
            pend_reg          <= 1'b0;
            pend_last_reg     <= 1'b0;
            sram_en_reg       <= 1'b0;
            sram_rw_reg       <= 1'b0;
            sram_addr_reg     <= '0;
            sram_din_reg      <= '0;
            frame_done_reg    <= 1'b0;
        end else begin
            sram_en_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
            issue_last_reg <= 1'b0;
            pend_reg       <= issue_now;
            pend_last_reg  <= issue_last_reg;

            // Readback start wins over a waiting write beat (Wr_Ready is low then)
            if ((state_reg == IDLE) && bus.Rd_Start) begin
                state_reg         <= RD;
                rd_cnt_reg        <= '0;
                rd_all_issued_reg <= 1'b0;
            end

            if (wr_fire) begin
                sram_en_reg   <= 1'b1;
                sram_rw_reg   <= 1'b1;
                sram_addr_reg <= wr_cnt_reg;
                sram_din_reg  <= bus.Wr_Data;
                if (wr_cnt_reg == LAST_ADDR) begin
                    wr_cnt_reg     <= '0;
                    frame_done_reg <= 1'b1;
                    state_reg      <= IDLE;
                end else begin
                    wr_cnt_reg <= wr_cnt_reg + A_WIDTH'(1);
                    state_reg  <= WR;
                end
            end

            if (rd_issue) begin
                sram_en_reg    <= 1'b1;
                sram_rw_reg    <= 1'b0;
                sram_addr_reg  <= rd_cnt_reg;
                issue_last_reg <= (rd_cnt_reg == LAST_ADDR);
                if (rd_cnt_reg == LAST_ADDR) begin
                    rd_cnt_reg        <= '0;
                    rd_all_issued_reg <= 1'b1;
                end else begin
                    rd_cnt_reg <= rd_cnt_reg + A_WIDTH'(1);
                end
            end

            // The final pixel leaving the buffer closes the readback
            if ((state_reg == RD) && pop && buf_last_reg[head_reg]) begin
                state_reg         <= IDLE;
                frame_done_reg    <= 1'b1;
                rd_all_issued_reg <= 1'b0;
            end
        end
    end

    // Output buffer: capture returning SRAM data, release the head on a read handshake
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_data_reg[i] <= '0;
                buf_last_reg[i] <= 1'b0;
            end
            head_reg <= 2'd0;
            tail_reg <= 2'd0;
            occ_reg  <= 3'd0;
        end else begin
            if (pend_reg) begin
                buf_data_reg[tail_reg] <= bus.Sram_Dout;
                buf_last_reg[tail_reg] <= pend_last_reg;
                tail_reg               <= tail_reg + 2'd1;
            end
            if (pop) begin
                head_reg <= head_reg + 2'd1;
            end
            occ_reg <= occ_reg + 3'(pend_reg) - 3'(pop);
        end
    end

    assign bus.Wr_Ready   = wr_ready;
    assign bus.Rd_Valid   = rd_valid;
    assign bus.Rd_Data    = buf_data_reg[head_reg];
    assign bus.Rd_Last    = rd_valid && buf_last_reg[head_reg];
    assign bus.Busy       = (state_reg != IDLE);
    assign bus.Frame_Done = frame_done_reg;
    assign bus.Sram_En    = sram_en_reg;
    assign bus.Sram_RW    = sram_rw_reg;
    assign bus.Sram_Addr  = sram_addr_reg;
    assign bus.Sram_Din   = sram_din_reg;
endmodule

// File: tb/tb_sram_frame_master.sv
// Directed bench for sram_frame_master on a reduced 32x10 frame so full write,
// readback, backpressure and reset-restart runs stay short. A behavioural SRAM
// with one-cycle read latency and zero-when-idle data sits on the SRAM side.
module tb_sram_frame_master;
    localparam int A_W  = 17;
    localparam int D_W  = 8;
    localparam int TW   = 32;
    localparam int TH   = 10;
    localparam int NPIX = TW * TH;

    logic Clk = 1'b0;
    logic Rst_n;

    sram_frame_master_if #(.A_WIDTH(A_W), .D_WIDTH(D_W)) bus ();

    sram_frame_master #(
        .A_WIDTH(A_W),
        .D_WIDTH(D_W),
        .IMG_W  (TW),
        .IMG_H  (TH)
    ) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    // Behavioural single-port SRAM
    logic [D_W-1:0] mem [NPIX];
    always @(posedge Clk) begin
        if (bus.Sram_En && bus.Sram_RW) mem[int'(bus.Sram_Addr)] <= bus.Sram_Din;
        bus.Sram_Dout <= (bus.Sram_En && !bus.Sram_RW) ? mem[int'(bus.Sram_Addr)] : '0;
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Monitor state, sampled on the falling edge
    int             wr_strobes = 0, exp_wr = 0, wr_err = 0;
    int             rd_strobes = 0, exp_rd = 0, rd_err = 0;
    int             hs_cnt = 0, pix_idx = 0, data_err = 0, last_cnt = 0;
    int             stall_err = 0, level = 0, max_level = 0, done_cnt = 0;
    logic           prev_stall = 1'b0;
    logic [D_W-1:0] prev_data = '0;

    always @(negedge Clk) begin
        if (!Rst_n) begin
            exp_rd     = 0;
            pix_idx    = 0;
            level      = 0;
            prev_stall = 1'b0;
        end else begin
            if (bus.Frame_Done) done_cnt++;
            if (bus.Sram_En && bus.Sram_RW) begin
                wr_strobes++;
                if (bus.Sram_Addr != A_W'(exp_wr) || bus.Sram_Din != D_W'(exp_wr)) wr_err++;
                exp_wr = (exp_wr + 1) % NPIX;
            end
            if (bus.Sram_En && !bus.Sram_RW) begin
                rd_strobes++;
                if (bus.Sram_Addr != A_W'(exp_rd)) rd_err++;
                exp_rd = (exp_rd + 1) % NPIX;
                level++;
            end
            if (level > max_level) max_level = level;
            if (prev_stall && (!bus.Rd_Valid || bus.Rd_Data != prev_data)) stall_err++;
            if (bus.Rd_Valid && bus.Rd_Ready) begin
                hs_cnt++;
                if (bus.Rd_Data != D_W'(pix_idx)) data_err++;
                if (bus.Rd_Last != (pix_idx == NPIX - 1)) data_err++;
                if (bus.Rd_Last) last_cnt++;
                pix_idx = (pix_idx + 1) % NPIX;
                level--;
            end
            prev_stall = bus.Rd_Valid && !bus.Rd_Ready;
            prev_data  = bus.Rd_Data;
        end
    end

    // One frame readback; timed runs check latency and back-to-back pixels at full rate,
    // untimed runs toggle Rd_Ready at ready_pct percent; with_wr also holds Wr_Valid at start
    task automatic do_read(input string tag, input int ready_pct, input bit timed, input bit with_wr);
        int hs0, de0, lc0, rs0, re0, d0, se0, ws0, cyc, bubbles;
        bit got_done;
        hs0 = hs_cnt; de0 = data_err; lc0 = last_cnt; rs0 = rd_strobes;
        re0 = rd_err; d0 = done_cnt; se0 = stall_err; ws0 = wr_strobes;
        bus.Rd_Ready = timed;
        bus.Rd_Start = 1'b1;
        if (with_wr) begin
            bus.Wr_Valid = 1'b1;
            bus.Wr_Data  = 8'hAA;
            #1;
            check({tag, "_wr_ready_at_start"}, bus.Wr_Ready, 0);
        end
        tick();
        bus.Rd_Start = 1'b0;
        if (timed) begin
            check({tag, "_busy"}, bus.Busy, 1);
            check({tag, "_wr_ready_in_rd"}, bus.Wr_Ready, 0);
            check({tag, "_valid_e0"}, bus.Rd_Valid, 0);
            tick();
            check({tag, "_first_en"}, bus.Sram_En, 1);
            check({tag, "_first_rw"}, bus.Sram_RW, 0);
            check({tag, "_first_addr"}, bus.Sram_Addr, 0);
            tick();
            check({tag, "_valid_e2"}, bus.Rd_Valid, 0);
            tick();
            check({tag, "_valid_e3"}, bus.Rd_Valid, 1);
            check({tag, "_data_px0"}, bus.Rd_Data, 0);
            bus.Wr_Valid = 1'b0;
            bubbles = 0;
            for (int k = 0; k < NPIX; k++) begin
                if (!bus.Rd_Valid) bubbles++;
                tick();
            end
            check({tag, "_bubbles"}, bubbles, 0);
            check({tag, "_done_pulse"}, bus.Frame_Done, 1);
            check({tag, "_busy_after"}, bus.Busy, 0);
        end else begin
            got_done = 1'b0;
            cyc = 0;
            while (!got_done && cyc < NPIX * 20) begin
                bus.Rd_Ready = ($urandom_range(0, 99) < ready_pct);
                tick();
                cyc++;
                if (bus.Frame_Done) got_done = 1'b1;
            end
            check({tag, "_finished_in_time"}, got_done, 1);
        end
        bus.Rd_Ready = 1'b0;
        bus.Wr_Valid = 1'b0;
        tick();
        tick();
        check({tag, "_pixels"}, hs_cnt - hs0, NPIX);
        check({tag, "_data_errs"}, data_err - de0, 0);
        check({tag, "_last_count"}, last_cnt - lc0, 1);
        check({tag, "_read_strobes"}, rd_strobes - rs0, NPIX);
        check({tag, "_read_addr_errs"}, rd_err - re0, 0);
        check({tag, "_done_count"}, done_cnt - d0, 1);
        check({tag, "_stall_errs"}, stall_err - se0, 0);
        check({tag, "_no_writes"}, wr_strobes - ws0, 0);
        $display("[%0t] %s: pixels=%0d data_errs=%0d stall_errs=%0d", $time, tag,
                 hs_cnt - hs0, data_err - de0, stall_err - se0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ws0, d0, nr, hs0, cyc;
        Rst_n        = 1'b0;
        bus.Wr_Valid = 1'b0;
        bus.Wr_Data  = '0;
        bus.Rd_Start = 1'b0;
        bus.Rd_Ready = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_wr_ready", bus.Wr_Ready, 1);
        check("rst_busy", bus.Busy, 0);
        check("rst_sram_en", bus.Sram_En, 0);
        check("rst_rd_valid", bus.Rd_Valid, 0);
        check("rst_frame_done", bus.Frame_Done, 0);
        check("rst_sram_addr", bus.Sram_Addr, 0);
        $display("[%0t] reset: wr_ready=%0d busy=%0d", $time, bus.Wr_Ready, bus.Busy);
        Rst_n = 1'b1;
        tick();

        // Write ramp: pixel i carries i[7:0], Wr_Valid held high for the whole frame
        ws0 = wr_strobes; d0 = done_cnt; nr = 0;
        for (int i = 0; i < NPIX; i++) begin
            bus.Wr_Valid = 1'b1;
            bus.Wr_Data  = D_W'(i);
            if (!bus.Wr_Ready) nr++;
            if (i == 5) check("wr_busy_mid", bus.Busy, 1);
            tick();
        end
        bus.Wr_Valid = 1'b0;
        check("wr_done_pulse", bus.Frame_Done, 1);
        check("wr_busy_after", bus.Busy, 0);
        check("wr_last_addr", bus.Sram_Addr, NPIX - 1);
        tick();
        check("wr_done_one_cycle", bus.Frame_Done, 0);
        tick();
        check("wr_not_ready_cycles", nr, 0);
        check("wr_strobes", wr_strobes - ws0, NPIX);
        check("wr_addr_data_errs", wr_err, 0);
        check("wr_done_count", done_cnt - d0, 1);
        $display("[%0t] write ramp: strobes=%0d", $time, wr_strobes - ws0);

        // Readbacks
        do_read("rd_full", 100, 1'b1, 1'b0);
        do_read("rd_bp", 30, 1'b0, 1'b0);
        check("rd_bp_max_outstanding", max_level, 4);
        do_read("rd_simul", 100, 1'b1, 1'b1);

        // Abort a readback part-way through, then restart from address 0
        hs0 = hs_cnt;
        bus.Rd_Ready = 1'b1;
        bus.Rd_Start = 1'b1;
        tick();
        bus.Rd_Start = 1'b0;
        cyc = 0;
        while ((hs_cnt - hs0) < 100 && cyc < 1000) begin
            tick();
            cyc++;
        end
        check("abort_reached_px", hs_cnt - hs0, 100);
        Rst_n = 1'b0;
        #2;
        check("abort_sram_en", bus.Sram_En, 0);
        check("abort_sram_rw", bus.Sram_RW, 0);
        check("abort_sram_addr", bus.Sram_Addr, 0);
        check("abort_sram_din", bus.Sram_Din, 0);
        check("abort_rd_valid", bus.Rd_Valid, 0);
        check("abort_rd_last", bus.Rd_Last, 0);
        check("abort_busy", bus.Busy, 0);
        check("abort_frame_done", bus.Frame_Done, 0);
        $display("[%0t] mid-read reset at pixel %0d", $time, hs_cnt - hs0);
        bus.Rd_Ready = 1'b0;
        tick();
        tick();
        Rst_n = 1'b1;
        tick();
        do_read("rd_restart", 100, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
